// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling FSM and
// sticky status flags (valid, frame error, overrun) for the bus register block.
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 434,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    input  logic       clear_i,
    output logic [7:0] rx_data_o,
    output logic       rx_flag_o,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       rx_busy_o,
    output logic [2:0] rx_state_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        START = 3'b001,
        DATA  = 3'b010,
        STOP  = 3'b011,
        DONE  = 3'b100
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          stop_q, stop_d;
    logic [7:0]    data_q, data_d;
    logic          flag_q, flag_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          rx_meta_q, rxs_q;

    // NOTE: every variable gets a default before the case statement, so no
    // path through this block can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        stop_d  = stop_q;
        data_d  = data_q;
        flag_d  = flag_q & ~clear_i;
        ferr_d  = ferr_q & ~clear_i;
        ovr_d   = ovr_q & ~clear_i;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxs_q) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    // A line that is high again at mid start bit was only a glitch.
                    if (!rxs_q) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxs_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    stop_d  = rxs_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
                data_d  = shift_q;
                // A completing frame outranks a simultaneous clear.
                if (stop_q) begin
                    flag_d = 1'b1;
                    if (flag_q) ovr_d = 1'b1;
                end else begin
                    ferr_d = 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others, matching real hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            stop_q    <= 1'b0;
            data_q    <= '0;
            flag_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            rx_meta_q <= rx_i;
            rxs_q     <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            stop_q    <= stop_d;
            data_q    <= data_d;
            flag_q    <= flag_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign rx_data_o   = data_q;
    assign rx_flag_o   = flag_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;
    assign rx_busy_o   = (state_q != IDLE);
    assign rx_state_o  = state_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: frames are serialized by tasks, expected results are
// queued at frame start and popped by a monitor one cycle after DONE.
module tb_uart_rx_ctrl;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_i;
    logic       clear_i;
    logic [7:0] rx_data_o;
    logic       rx_flag_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       rx_busy_o;
    logic [2:0] rx_state_o;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_i       (rx_i),
        .clear_i    (clear_i),
        .rx_data_o  (rx_data_o),
        .rx_flag_o  (rx_flag_o),
        .frame_err_o(frame_err_o),
        .overrun_o  (overrun_o),
        .rx_busy_o  (rx_busy_o),
        .rx_state_o (rx_state_o)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       flag;
        logic       ferr;
        logic       ovr;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         n_vec = 0;
    int         n_err = 0;
    logic [2:0] prev_state = 3'b000;

    logic [7:0] m_data;
    logic       m_flag, m_ferr, m_ovr;

    // Monitor: results are visible the cycle after the DUT leaves DONE.
    always @(negedge clk) begin
        if (prev_state == 3'b100) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_frame: got data %h with no frame queued", rx_data_o);
            end else begin
                mon_e = sb_q.pop_front();
                n_vec++;
                if (rx_data_o !== mon_e.data) begin
                    n_err++;
                    $display("FAIL frame_data: got %h want %h", rx_data_o, mon_e.data);
                end
                n_vec++;
                if (rx_flag_o !== mon_e.flag) begin
                    n_err++;
                    $display("FAIL frame_flag(%h): got %b want %b", mon_e.data, rx_flag_o, mon_e.flag);
                end
                n_vec++;
                if (frame_err_o !== mon_e.ferr) begin
                    n_err++;
                    $display("FAIL frame_ferr(%h): got %b want %b", mon_e.data, frame_err_o, mon_e.ferr);
                end
                n_vec++;
                if (overrun_o !== mon_e.ovr) begin
                    n_err++;
                    $display("FAIL frame_ovr(%h): got %b want %b", mon_e.data, overrun_o, mon_e.ovr);
                end
            end
        end
        prev_state <= rx_state_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic stop);
        exp_t e;
        m_data = d;
        if (stop) begin
            m_ovr  = m_ovr | m_flag;
            m_flag = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
        e.data = m_data;
        e.flag = m_flag;
        e.ferr = m_ferr;
        e.ovr  = m_ovr;
        sb_q.push_back(e);
    endtask

    task automatic drive_bit(input logic b, input bit chk_busy);
        rx_i = b;
        for (int i = 0; i < CPB; i++) begin
            tick();
            if (chk_busy && i == CPB / 2) begin
                n_vec++;
                if (rx_busy_o !== 1'b1) begin
                    n_err++;
                    $display("FAIL busy_mid_frame: got %b want 1", rx_busy_o);
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop, input bit chk_busy);
        expect_frame(d, stop);
        drive_bit(1'b0, chk_busy);
        for (int i = 0; i < 8; i++) drive_bit(d[i], chk_busy);
        drive_bit(stop, chk_busy);
        rx_i = 1'b1;
    endtask

    task automatic check_flags(input string tag);
        n_vec++;
        if ({rx_data_o, rx_flag_o, frame_err_o, overrun_o} !== {m_data, m_flag, m_ferr, m_ovr}) begin
            n_err++;
            $display("FAIL %s: got data=%h flag=%b ferr=%b ovr=%b want data=%h flag=%b ferr=%b ovr=%b",
                     tag, rx_data_o, rx_flag_o, frame_err_o, overrun_o, m_data, m_flag, m_ferr, m_ovr);
        end
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        m_flag = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        check_flags("after_clear");
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        rx_i    = 1'b1;
        clear_i = 1'b0;
        m_data  = 8'h00;
        m_flag  = 1'b0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
        repeat (3) tick();
        check_flags("reset_outputs");
        n_vec++;
        if ({rx_busy_o, rx_state_o} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b state=%b want busy=0 state=000", rx_busy_o, rx_state_o);
        end
        rst = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_basic();
        send_byte(8'hA5, 1'b1, 1'b1);
        tick();
        n_vec++;
        if (rx_busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL busy_after_frame: got %b want 0", rx_busy_o);
        end
    endtask

    task automatic test_glitch();
        rx_i = 1'b0;
        repeat (4) tick();
        rx_i = 1'b1;
        n_vec++;
        if (rx_state_o !== 3'b001) begin
            n_err++;
            $display("FAIL glitch_start: got state %b want 001", rx_state_o);
        end
        repeat (6) tick();
        n_vec++;
        if (rx_busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL glitch_busy_last_start_cycle: got %b want 1", rx_busy_o);
        end
        tick();
        n_vec++;
        if ({rx_busy_o, rx_state_o} !== 4'b0000) begin
            n_err++;
            $display("FAIL glitch_idle: got busy=%b state=%b want busy=0 state=000", rx_busy_o, rx_state_o);
        end
        check_flags("glitch_flags");
    endtask

    task automatic test_frame_error();
        send_byte(8'h3C, 1'b0, 1'b0);
        repeat (3 * CPB) tick();
        n_vec++;
        if (rx_state_o !== 3'b000) begin
            n_err++;
            $display("FAIL ferr_recover_idle: got state %b want 000", rx_state_o);
        end
        check_flags("ferr_hold");
        pulse_clear();
    endtask

    task automatic test_back_to_back();
        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h22, 1'b1, 1'b0);
        repeat (4) tick();
        check_flags("overrun_hold");
        pulse_clear();
    endtask

    task automatic test_clear_in_done();
        bit seen = 1'b0;
        fork
            send_byte(8'h7E, 1'b1, 1'b0);
            begin
                for (int i = 0; i < 12 * CPB && !seen; i++) begin
                    tick();
                    if (rx_state_o == 3'b100) begin
                        seen    = 1'b1;
                        clear_i = 1'b1;
                        tick();
                        clear_i = 1'b0;
                    end
                end
            end
        join
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL done_timeout: got no DONE state want DONE within %0d cycles", 12 * CPB);
        end
        repeat (2) tick();
        check_flags("set_wins_hold");
    endtask

    task automatic test_reset_mid_frame();
        rx_i = 1'b0;
        repeat (CPB) tick();
        rx_i = 1'b1;
        repeat (4 * CPB + CPB / 2) tick();
        rst = 1'b1;
        tick();
        m_data = 8'h00;
        m_flag = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        check_flags("midframe_reset_outputs");
        n_vec++;
        if ({rx_busy_o, rx_state_o} !== 4'b0000) begin
            n_err++;
            $display("FAIL midframe_reset_state: got busy=%b state=%b want busy=0 state=000", rx_busy_o, rx_state_o);
        end
        rst = 1'b0;
        repeat (2 * CPB) tick();
        send_byte(8'h81, 1'b1, 1'b0);
        repeat (4) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion want finish before 100000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_clear_in_done();
        test_reset_mid_frame();
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL frames_outstanding: got %0d unreceived want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
